// File: rtl/ring_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : ring_seq_core
// Description : Prescaled pattern sequencer. Every div+1 enabled cycles the
//               ring register steps through one of four patterns (rotate,
//               Johnson, bounce, fill). tick marks each new value; wrap marks
//               a return to the last loaded (or reset) origin value.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_seq_core #(
  parameter int WIDTH = 8,   // ring length in bits, 2..32
  parameter int DIV_W = 16   // prescaler counter width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] ring,
  output logic             tick,
  output logic             wrap
);

  localparam logic [1:0] MODE_ROTATE  = 2'b00;
  localparam logic [1:0] MODE_JOHNSON = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] MODE_FILL    = 2'b11;

  localparam logic [WIDTH-1:0] RING_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] ring_q,   ring_d;
  logic [WIDTH-1:0] origin_q, origin_d;
  logic [DIV_W-1:0] cnt_q,    cnt_d;
  logic             bdir_q,   bdir_d;
  logic             tick_q,   tick_d;
  logic             wrap_q,   wrap_d;

  logic [WIDTH-1:0] step_ring;
  logic             step_bdir;
  logic             ring_zero;

  assign ring_zero = (ring_q == '0);

  // Pattern generator: the value (and bounce direction) a step would produce.
  always_comb begin
    step_ring = ring_q;
    step_bdir = bdir_q;
    case (mode)
      MODE_ROTATE: begin
        if (ring_zero) begin
          // All-zero is a fixed point of rotation; reseed with bit 0.
          step_ring = RING_ONE;
          step_bdir = 1'b0;
        end else if (dir) begin
          step_ring = {ring_q[0], ring_q[WIDTH-1:1]};
        end else begin
          step_ring = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
        end
      end
      MODE_JOHNSON: begin
        if (dir) begin
          step_ring = {~ring_q[0], ring_q[WIDTH-1:1]};
        end else begin
          step_ring = {ring_q[WIDTH-2:0], ~ring_q[WIDTH-1]};
        end
      end
      MODE_BOUNCE: begin
        if (ring_zero) begin
          step_ring = RING_ONE;
          step_bdir = 1'b0;
        end else if (!bdir_q) begin
          // Moving up: turn around once the MSB end is reached.
          if (ring_q[WIDTH-1]) begin
            step_ring = ring_q >> 1;
            step_bdir = 1'b1;
          end else begin
            step_ring = ring_q << 1;
          end
        end else begin
          // Moving down: turn around once the LSB end is reached.
          if (ring_q[0]) begin
            step_ring = ring_q << 1;
            step_bdir = 1'b0;
          end else begin
            step_ring = ring_q >> 1;
          end
        end
      end
      MODE_FILL: begin
        if (&ring_q) begin
          step_ring = '0;
        end else if (dir) begin
          step_ring = {1'b1, ring_q[WIDTH-1:1]};
        end else begin
          step_ring = {ring_q[WIDTH-2:0], 1'b1};
        end
      end
      default: begin
        step_ring = ring_q;
        step_bdir = bdir_q;
      end
    endcase
  end

  // Next-state: load beats everything, en=0 freezes, prescaler gates steps.
  always_comb begin
    ring_d   = ring_q;
    origin_d = origin_q;
    cnt_d    = cnt_q;
    bdir_d   = bdir_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    if (load) begin
      ring_d   = load_val;
      origin_d = load_val;
      cnt_d    = '0;
      bdir_d   = 1'b0;
    end else if (en) begin
      // >= rather than == so lowering div below cnt steps immediately.
      if (cnt_q >= div) begin
        cnt_d  = '0;
        ring_d = step_ring;
        bdir_d = step_bdir;
        tick_d = 1'b1;
        wrap_d = (step_ring == origin_q);
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_q   <= RING_ONE;
      origin_q <= RING_ONE;
      cnt_q    <= '0;
      bdir_q   <= 1'b0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      ring_q   <= ring_d;
      origin_q <= origin_d;
      cnt_q    <= cnt_d;
      bdir_q   <= bdir_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
    end
  end

  assign ring = ring_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_seq_core
// Description : Directed bench for ring_seq_core (WIDTH=8, DIV_W=16): a
//               vector table plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_seq_core;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic        dir;
  logic        load;
  logic [7:0]  load_val;
  logic [15:0] div;
  logic [7:0]  ring;
  logic        tick;
  logic        wrap;

  int n_total = 0;
  int n_pass  = 0;

  ring_seq_core #(.WIDTH(8), .DIV_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .div      (div),
    .ring     (ring),
    .tick     (tick),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic        dir;
    logic        load;
    logic [7:0]  lv;
    logic [15:0] dv;
    logic [7:0]  x_ring;
    logic        x_tick;
    logic        x_wrap;
  } vec_t;

  vec_t vq[$];
  logic [7:0] seq[$];

  task automatic add(input logic e, input logic [1:0] m, input logic d, input logic l,
                     input logic [7:0] lv, input logic [15:0] dv,
                     input logic [7:0] r, input logic t, input logic w);
    vec_t v;
    v.en = e; v.mode = m; v.dir = d; v.load = l; v.lv = lv; v.dv = dv;
    v.x_ring = r; v.x_tick = t; v.x_wrap = w;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset(input string nm);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk({nm, " rst ring"}, ring, 8'h01);
    chk({nm, " rst tick"}, tick, 1'b0);
    chk({nm, " rst wrap"}, wrap, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Steps through seq[] with period div+1; wrap expected only on the last entry.
  task automatic run_seq(input string nm, input int period);
    for (int k = 0; k < seq.size(); k++) begin
      for (int c = 0; c < period - 1; c++) begin
        cyc();
        chk($sformatf("%s idle%0d tick", nm, k), tick, 1'b0);
      end
      cyc();
      chk($sformatf("%s step%0d ring", nm, k), ring, seq[k]);
      chk($sformatf("%s step%0d tick", nm, k), tick, 1'b1);
      chk($sformatf("%s step%0d wrap", nm, k), wrap, (k == seq.size() - 1) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; dir = 1'b0; load = 1'b0;
    load_val = 8'h00; div = 16'd0;

    //   en mode dir ld  lv     div    ring  tk wr
    add(1, 2'd0, 0, 0, 8'h00, 16'd0, 8'h02, 1, 0);
    add(1, 2'd0, 0, 0, 8'h00, 16'd0, 8'h04, 1, 0);
    add(1, 2'd0, 0, 0, 8'h00, 16'd0, 8'h08, 1, 0);
    add(1, 2'd0, 0, 0, 8'h00, 16'd0, 8'h10, 1, 0);
    add(1, 2'd0, 0, 0, 8'h00, 16'd0, 8'h20, 1, 0);
    add(1, 2'd0, 0, 0, 8'h00, 16'd0, 8'h40, 1, 0);
    add(1, 2'd0, 0, 0, 8'h00, 16'd0, 8'h80, 1, 0);
    add(1, 2'd0, 0, 0, 8'h00, 16'd0, 8'h01, 1, 1);
    add(0, 2'd0, 0, 0, 8'h00, 16'd0, 8'h01, 0, 0);
    add(1, 2'd0, 0, 1, 8'h81, 16'd0, 8'h81, 0, 0);
    add(1, 2'd0, 1, 0, 8'h00, 16'd0, 8'hC0, 1, 0);
    add(1, 2'd0, 1, 0, 8'h00, 16'd0, 8'h60, 1, 0);
    add(0, 2'd0, 1, 0, 8'h00, 16'd0, 8'h60, 0, 0);
    add(1, 2'd1, 1, 0, 8'h00, 16'd0, 8'hB0, 1, 0);
    add(1, 2'd1, 0, 0, 8'h00, 16'd0, 8'h60, 1, 0);
    add(1, 2'd3, 1, 0, 8'h00, 16'd0, 8'hB0, 1, 0);
    add(1, 2'd3, 0, 0, 8'h00, 16'd0, 8'h61, 1, 0);
    add(1, 2'd3, 0, 1, 8'hFF, 16'd0, 8'hFF, 0, 0);
    add(1, 2'd3, 0, 0, 8'h00, 16'd0, 8'h00, 1, 0);
    add(1, 2'd3, 0, 0, 8'h00, 16'd0, 8'h01, 1, 0);
    add(1, 2'd0, 0, 1, 8'h00, 16'd0, 8'h00, 0, 0);
    add(1, 2'd0, 0, 0, 8'h00, 16'd0, 8'h01, 1, 0);
    add(1, 2'd0, 0, 0, 8'h00, 16'd0, 8'h02, 1, 0);
    add(1, 2'd2, 0, 1, 8'h00, 16'd0, 8'h00, 0, 0);
    add(1, 2'd2, 0, 0, 8'h00, 16'd0, 8'h01, 1, 0);
    add(1, 2'd2, 0, 0, 8'h00, 16'd0, 8'h02, 1, 0);
    add(1, 2'd0, 0, 0, 8'h00, 16'd2, 8'h02, 0, 0);
    add(1, 2'd0, 0, 0, 8'h00, 16'd2, 8'h02, 0, 0);
    add(1, 2'd0, 0, 0, 8'h00, 16'd2, 8'h04, 1, 0);
    add(1, 2'd0, 0, 0, 8'h00, 16'd2, 8'h04, 0, 0);
    add(1, 2'd0, 0, 0, 8'h00, 16'd0, 8'h08, 1, 0);

    // ---------------- table ----------------
    do_reset("tbl");
    for (int i = 0; i < vq.size(); i++) begin
      en = vq[i].en; mode = vq[i].mode; dir = vq[i].dir;
      load = vq[i].load; load_val = vq[i].lv; div = vq[i].dv;
      cyc();
      chk($sformatf("row%0d ring", i), ring, vq[i].x_ring);
      chk($sformatf("row%0d tick", i), tick, vq[i].x_tick);
      chk($sformatf("row%0d wrap", i), wrap, vq[i].x_wrap);
    end
    load = 1'b0;

    // ---------------- Johnson, div=2 ----------------
    en = 1'b1; mode = 2'd1; dir = 1'b0; div = 16'd2;
    do_reset("john");
    seq = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE,
            8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
    run_seq("john", 3);

    // ---------------- bounce, div=0 ----------------
    mode = 2'd2; div = 16'd0;
    do_reset("bnc");
    seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    run_seq("bnc", 1);
    cyc();
    chk("bnc turn ring", ring, 8'h02);
    chk("bnc turn wrap", wrap, 1'b0);

    // ---------------- fill, dir=0 ----------------
    mode = 2'd3; dir = 1'b0;
    do_reset("fill");
    seq = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};
    run_seq("fill", 1);

    // ---------------- en pause mid-count, div=5 ----------------
    mode = 2'd0; dir = 1'b0; div = 16'd5; en = 1'b1;
    do_reset("pause");
    for (int c = 0; c < 2; c++) begin
      cyc(); chk($sformatf("pause pre%0d tick", c), tick, 1'b0);
    end
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk($sformatf("pause hold%0d tick", c), tick, 1'b0);
      chk($sformatf("pause hold%0d ring", c), ring, 8'h01);
    end
    en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc(); chk($sformatf("pause post%0d tick", c), tick, 1'b0);
    end
    cyc();
    chk("pause step tick", tick, 1'b1);
    chk("pause step ring", ring, 8'h02);
    // load in the cycle a step would occur
    for (int c = 0; c < 5; c++) begin
      cyc(); chk($sformatf("ldstep pre%0d tick", c), tick, 1'b0);
    end
    load = 1'b1; load_val = 8'h55;
    cyc();
    chk("ldstep ring", ring, 8'h55);
    chk("ldstep tick", tick, 1'b0);
    chk("ldstep wrap", wrap, 1'b0);
    load = 1'b0;
    cyc();
    chk("ldstep after tick", tick, 1'b0);
    chk("ldstep after ring", ring, 8'h55);

    // ---------------- reset mid-count in bounce while moving down ----------------
    mode = 2'd2; div = 16'd0; en = 1'b1;
    do_reset("mr");
    for (int c = 0; c < 8; c++) cyc();
    chk("mr down ring", ring, 8'h40);
    div = 16'd3;
    cyc(); cyc();
    chk("mr mid tick", tick, 1'b0);
    do_reset("mr2");
    for (int c = 0; c < 3; c++) begin
      cyc(); chk($sformatf("mr2 idle%0d tick", c), tick, 1'b0);
    end
    cyc();
    chk("mr2 step ring", ring, 8'h02);
    chk("mr2 step tick", tick, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
